stereo_sample_pairer: RTL

STEREO_SAMPLE_PAIRER -- requirements
Module: stereo_sample_pairer

---
 rtl/audio_defs.sv | 21 ++
 rtl/sync_fifo.sv | 91 +++++++++
 rtl/stereo_sample_pairer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/audio_defs.sv
// -----------------------------------------------------------------------------
// audio_defs
//   Shared definitions for the stereo audio path: default channel sample width,
//   stereo frame width, and the encoding of the left/right pairing state.
//   The pairing states are plain localparam constants so that older blocks
//   can compare against them without depending on an enum type.
// -----------------------------------------------------------------------------
package audio_defs;

    // Default width of one channel sample, MSB-aligned.
    localparam int AUDIO_WIDTH = 32;

    // One stereo frame is a left sample followed by a right sample.
    localparam int FRAME_WIDTH = 2 * AUDIO_WIDTH;

    // Pairing state encoding.
    typedef logic [0:0] pair_state_t;
    localparam pair_state_t WAIT_L = 1'b0; // no left sample held
    localparam pair_state_t HAVE_L = 1'b1; // left sample waiting for its right partner

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO of fixed-width words with a sticky overflow flag.
//   depth must be a power of two (>= 2) so the pointers wrap by truncation.
//   The head word is shown combinationally on pop_data and reads as zero
//   while the FIFO is empty.
//
// Ports
//   sclk      in   clock, rising edge
//   reset_n   in   synchronous active-low reset
//   push      in   write push_data at the tail this cycle
//   push_data in   word to write
//   pop       in   remove the head word this cycle (ignored when empty)
//   pop_data  out  current head word (zero when empty)
//   level     out  number of words stored, 0..depth
//   overflow  out  sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int width = 64,
    parameter int depth = 4
) (
    input  logic                     sclk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [width-1:0]         push_data,
    input  logic                     pop,
    output logic [width-1:0]         pop_data,
    output logic [$clog2(depth):0]   level,
    output logic                     overflow
);

    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w:0] full_level = (ptr_w + 1)'(depth);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w:0]   level_q;
    logic             overflow_q;

    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty = (level_q == '0);
    assign full  = (level_q == full_level);

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still succeeds when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: the storage array carries no reset; only pointers and level do.
    // Stale words are unreachable because the head is masked while empty,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sclk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_q
                       + {{ptr_w{1'b0}}, do_push}
                       - {{ptr_w{1'b0}}, do_pop};
            if (push & ~do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/stereo_sample_pairer.sv
// -----------------------------------------------------------------------------
// stereo_sample_pairer
//   Collects left/right channel samples from an upstream serial decoder,
//   pairs each left sample with the next right sample into a stereo frame,
//   and buffers the frames in a small FIFO for the downstream consumer.
//   Out-of-order samples are discarded with a one-cycle pair_error pulse;
//   an upstream framing error silently drops any partial frame.
//
// Ports
//   sclk        in   sole clock, rising edge
//   reset_n     in   synchronous active-low reset
//   in_valid    in   upstream has a channel sample
//   in_ready    out  sample accepted this cycle (low only during reset)
//   in_is_left  in   1 = left channel sample, 0 = right
//   in_audio    in   channel sample, MSB-aligned
//   in_error    in   upstream framing error level
//   out_valid   out  a stereo frame is at the FIFO head
//   out_ready   in   downstream consumes the head frame
//   out_left    out  left sample of the head frame
//   out_right   out  right sample of the head frame
//   fifo_level  out  frames stored, 0..fifo_depth
//   overflow    out  sticky: a frame was dropped because the FIFO was full
//   pair_error  out  one-cycle pulse on a channel-order violation
// -----------------------------------------------------------------------------
module stereo_sample_pairer
    import audio_defs::*;
#(
    parameter int audio_width = AUDIO_WIDTH,
    parameter int fifo_depth  = 4
) (
    input  logic                          sclk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_is_left,
    input  logic [audio_width-1:0]        in_audio,
    input  logic                          in_error,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [audio_width-1:0]        out_left,
    output logic [audio_width-1:0]        out_right,
    output logic [$clog2(fifo_depth):0]   fifo_level,
    output logic                          overflow,
    output logic                          pair_error
);

    localparam int frame_width = 2 * audio_width;

    pair_state_t              state;
    pair_state_t              state_next;
    logic [audio_width-1:0]   hold_left;
    logic [audio_width-1:0]   hold_left_next;
    logic                     pair_error_q;
    logic                     pair_error_next;

    logic                     accept;
    logic                     frame_push;
    logic [frame_width-1:0]   frame_data;
    logic [frame_width-1:0]   head_frame;

    // The block is always able to take a sample; only reset holds it off.
    assign in_ready = reset_n;
    assign accept   = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // Pairing decision
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the branches can leave it unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        hold_left_next  = hold_left;
        pair_error_next = 1'b0;
        frame_push      = 1'b0;
        frame_data      = {hold_left, in_audio};

        if (in_error) begin
            // A framing error invalidates whatever is in flight; it is the
            // decoder's fault, not an ordering violation, so no pair_error.
            state_next     = WAIT_L;
            hold_left_next = '0;
        end else if (accept) begin
            case (state)
                WAIT_L: begin
                    if (in_is_left) begin
                        hold_left_next = in_audio;
                        state_next     = HAVE_L;
                    end else begin
                        pair_error_next = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (in_is_left) begin
                        // A newer left sample replaces the orphaned one.
                        hold_left_next  = in_audio;
                        pair_error_next = 1'b1;
                    end else begin
                        frame_push = 1'b1;
                        state_next = WAIT_L;
                    end
                end
                default: begin
                    state_next = WAIT_L;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (!reset_n) begin
            state        <= WAIT_L;
            hold_left    <= '0;
            pair_error_q <= 1'b0;
        end else begin
            state        <= state_next;
            hold_left    <= hold_left_next;
            pair_error_q <= pair_error_next;
        end
    end

    assign pair_error = pair_error_q;

    // -------------------------------------------------------------------------
    // Frame buffer
    // -------------------------------------------------------------------------
    sync_fifo #(
        .width (frame_width),
        .depth (fifo_depth)
    ) u_frame_fifo (
        .sclk      (sclk),
        .reset_n   (reset_n),
        .push      (frame_push),
        .push_data (frame_data),
        .pop       (out_ready),
        .pop_data  (head_frame),
        .level     (fifo_level),
        .overflow  (overflow)
    );

    assign out_valid = (fifo_level != '0);
    assign out_left  = head_frame[frame_width-1:audio_width];
    assign out_right = head_frame[audio_width-1:0];

endmodule
